// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor
//   Consumer of a free-running asynchronous (ripple) counter.
//   The raw counter value is brought into the clk domain through a
//   two-flop synchronizer. A value is accepted only once STABLE_N
//   consecutive synchronized samples agree, so ripple intermediates
//   are filtered out. Each accepted change is checked as a single
//   step in the DIR direction. Wrap-arounds are counted into wrap_cnt.
//   Any other jump raises a sticky error.
//
//   Optional feature macro: RCM_AUTORESYNC_EN
//     defined   : ERR re-locks onto the next settled value (err stays set)
//     undefined : ERR is held until clr or reset
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   q_in       raw ripple counter output (asynchronous to clk)
//   clr        synchronous clear back to INIT (synchronizer untouched)
//   count_out  last accepted count value
//   full_count {wrap_cnt, count_out}
//   step_valid one-cycle pulse per accepted legal step
//   wrap_pulse one-cycle pulse when a step crosses the wrap boundary
//   err        sticky illegal-jump flag
//   state      0 INIT, 1 TRACK, 2 ERR
module ripple_count_monitor #(
   parameter int CNT_W    = 3,
   parameter int EXT_W    = 8,
   parameter int STABLE_N = 2,
   parameter bit DIR      = 1'b0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [CNT_W-1:0]       q_in,
   input  logic                   clr,
   output logic [CNT_W-1:0]       count_out,
   output logic [EXT_W+CNT_W-1:0] full_count,
   output logic                   step_valid,
   output logic                   wrap_pulse,
   output logic                   err,
   output logic [1:0]             state
);

   typedef enum logic [1:0] {
      S_INIT  = 2'd0,
      S_TRACK = 2'd1,
      S_ERR   = 2'd2
   } state_t;

   // ---------------------------------------------------------------
   // Synchronizer and settle window
   // ---------------------------------------------------------------
   logic [CNT_W-1:0]                 s1, s2;
   // The settle window is s2 plus the STABLE_N-1 older s2 samples.
   logic [STABLE_N-2:0][CNT_W-1:0]   hist;
   // One valid bit per pipeline slot (s1, s2, hist...). Without it the
   // all-zero reset contents would look settled and INIT would lock onto
   // a value that never came from the counter.
   logic [STABLE_N:0]                vld_pipe;
   logic                             same;
   logic                             settled;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1       <= '0;
         s2       <= '0;
         hist     <= '0;
         vld_pipe <= '0;
      end else begin
         s1       <= q_in;
         s2       <= s1;
         hist[0]  <= s2;
         for (int i = 1; i < STABLE_N-1; i++) hist[i] <= hist[i-1];
         vld_pipe <= {vld_pipe[STABLE_N-1:0], 1'b1};
      end
   end

   always_comb begin
      same = 1'b1;
      for (int i = 0; i < STABLE_N-1; i++)
         if (hist[i] != s2) same = 1'b0;
   end

   assign settled = same && (&vld_pipe[STABLE_N:1]);

   // ---------------------------------------------------------------
   // Step checker FSM
   // ---------------------------------------------------------------
   state_t           state_q, state_nx;
   logic [EXT_W-1:0] wrap_cnt, wrap_nx;
   logic [CNT_W-1:0] count_nx, step_tgt;
   logic             err_nx, step_nx, wpulse_nx, wrap_step;

   assign step_tgt  = DIR ? (count_out + CNT_W'(1)) : (count_out - CNT_W'(1));
   // A legal step out of this value crosses the wrap boundary.
   assign wrap_step = DIR ? (count_out == '1) : (count_out == '0);

   always_comb begin
      state_nx  = state_q;
      count_nx  = count_out;
      wrap_nx   = wrap_cnt;
      err_nx    = err;
      step_nx   = 1'b0;
      wpulse_nx = 1'b0;
      if (clr) begin
         // clr outranks any step arriving on the same edge
         state_nx = S_INIT;
         count_nx = '0;
         wrap_nx  = '0;
         err_nx   = 1'b0;
      end else begin
         case (state_q)
            S_INIT: begin
               if (settled) begin
                  count_nx = s2;
                  state_nx = S_TRACK;
               end
            end
            S_TRACK: begin
               if (settled && (s2 != count_out)) begin
                  if (s2 == step_tgt) begin
                     count_nx = s2;
                     step_nx  = 1'b1;
                     if (wrap_step) begin
                        wpulse_nx = 1'b1;
                        wrap_nx   = wrap_cnt + EXT_W'(1);
                     end
                  end else begin
                     err_nx   = 1'b1;
                     state_nx = S_ERR;
                  end
               end
            end
            S_ERR: begin
`ifdef RCM_AUTORESYNC_EN
               // Re-lock silently; err stays set as a record of the event.
               if (settled) begin
                  count_nx = s2;
                  state_nx = S_TRACK;
               end
`endif
            end
            default: state_nx = S_INIT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_INIT;
         count_out  <= '0;
         wrap_cnt   <= '0;
         err        <= 1'b0;
         step_valid <= 1'b0;
         wrap_pulse <= 1'b0;
      end else begin
         state_q    <= state_nx;
         count_out  <= count_nx;
         wrap_cnt   <= wrap_nx;
         err        <= err_nx;
         step_valid <= step_nx;
         wrap_pulse <= wpulse_nx;
      end
   end

   assign full_count = {wrap_cnt, count_out};
   assign state      = state_q;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed bench for ripple_count_monitor with default parameters
// (CNT_W=3, EXT_W=8, STABLE_N=2, DIR=0).
module tb_ripple_count_monitor;

   localparam int ST_INIT  = 0;
   localparam int ST_TRACK = 1;
   localparam int ST_ERR   = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  q_in;
   logic        clr;
   logic [2:0]  count_out;
   logic [10:0] full_count;
   logic        step_valid;
   logic        wrap_pulse;
   logic        err;
   logic [1:0]  state;

   int n_chk = 0;
   int n_err = 0;
   int n_step = 0;
   int n_wrap = 0;
   int base_step;
   int base_wrap;

   ripple_count_monitor dut (
      .clk        (clk),
      .reset      (reset),
      .q_in       (q_in),
      .clr        (clr),
      .count_out  (count_out),
      .full_count (full_count),
      .step_valid (step_valid),
      .wrap_pulse (wrap_pulse),
      .err        (err),
      .state      (state)
   );

   always #5 clk = ~clk;

   // Pulses last one full cycle, so each is seen on exactly one falling edge.
   always @(negedge clk) begin
      if (step_valid) n_step <= n_step + 1;
      if (wrap_pulse) n_wrap <= n_wrap + 1;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic [2:0] v, input int n);
      q_in = v;
      repeat (n) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // ---------------- reset state ----------------
      reset = 1'b0;
      q_in  = 3'd7;
      clr   = 1'b0;
      repeat (3) tick();
      chk("rst_state", 32'(state), ST_INIT);
      chk("rst_full",  32'(full_count), 0);
      chk("rst_err",   32'(err), 0);
      chk("rst_pulse", 32'({step_valid, wrap_pulse}), 0);

      // ---------------- reset release, q_in=7 held ----------------
      reset = 1'b1;
      tick(); tick(); tick();                  // E0, E1, E2
      chk("lock_early_state", 32'(state), ST_INIT);
      tick();                                  // E3
      chk("lock_state", 32'(state), ST_TRACK);
      chk("lock_count", 32'(count_out), 7);
      chk("lock_full",  32'(full_count), 32'h007);
      repeat (4) tick();
      chk("lock_nostep", 32'(n_step), 0);

      // ---------------- down sequence with latency detail ----------------
      q_in = 3'd6;
      tick(); tick(); tick();                  // E0..E2
      chk("lat_before", 32'(count_out), 7);
      tick();                                  // E3
      chk("lat_count", 32'(count_out), 6);
      chk("lat_pulse", 32'(step_valid), 1);
      tick();
      chk("lat_pulse_end", 32'(step_valid), 0);
      repeat (5) tick();
      for (int v = 5; v >= 0; v--) hold(3'(v), 10);
      hold(3'd7, 10);
      chk("seq_steps", 32'(n_step), 8);
      chk("seq_wraps", 32'(n_wrap), 1);
      chk("seq_full",  32'(full_count), 32'h00F);
      chk("seq_err",   32'(err), 0);

      // ---------------- illegal jump from 5 ----------------
      hold(3'd6, 10);
      hold(3'd5, 10);
      chk("pre_jump_count", 32'(count_out), 5);
      base_step = n_step;
      hold(3'd2, 10);
      chk("jump_err", 32'(err), 1);
`ifdef RCM_AUTORESYNC_EN
      chk("jump_resync_state", 32'(state), ST_TRACK);
      chk("jump_resync_count", 32'(count_out), 2);
      chk("jump_resync_nostep", 32'(n_step), 32'(base_step));
      hold(3'd5, 10);
`else
      chk("jump_state", 32'(state), ST_ERR);
      chk("jump_count", 32'(count_out), 5);
      chk("jump_nostep", 32'(n_step), 32'(base_step));
      hold(3'd4, 10);                          // legal from 5, must be ignored
      chk("err_ignore_count", 32'(count_out), 5);
      chk("err_ignore_state", 32'(state), ST_ERR);
      chk("err_ignore_nostep", 32'(n_step), 32'(base_step));
      hold(3'd5, 10);
`endif
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_state", 32'(state), ST_INIT);
      chk("clr_full",  32'(full_count), 0);
      chk("clr_err",   32'(err), 0);
      base_step = n_step;
      base_wrap = n_wrap;
      tick();
      chk("clr_resync_state", 32'(state), ST_TRACK);
      chk("clr_resync_count", 32'(count_out), 5);
      tick();
      chk("clr_resync_nopulse", 32'(n_step + n_wrap), 32'(base_step + base_wrap));

      // ---------------- one-cycle glitch ----------------
      base_step = n_step;
      q_in = 3'd4;
      tick();
      hold(3'd5, 10);
      chk("glitch_nostep", 32'(n_step), 32'(base_step));
      chk("glitch_err",    32'(err), 0);
      chk("glitch_count",  32'(count_out), 5);

      // ---------------- clr coinciding with a legal step ----------------
      base_step = n_step;
      q_in = 3'd4;
      tick(); tick(); tick();                  // E0..E2, step due at E3
      clr = 1'b1;
      tick();                                  // E3
      clr = 1'b0;
      chk("clrstep_state", 32'(state), ST_INIT);
      chk("clrstep_full",  32'(full_count), 0);
      chk("clrstep_pulse", 32'(step_valid), 0);
      tick();
      chk("clrstep_resync", 32'(count_out), 4);
      tick();
      chk("clrstep_nostep", 32'(n_step), 32'(base_step));

      // ---------------- asynchronous reset mid-cycle ----------------
      hold(3'd1, 10);                          // illegal from 4
      chk("pre_rst_err", 32'(err), 1);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_state", 32'(state), ST_INIT);
      chk("arst_full",  32'(full_count), 0);
      chk("arst_err",   32'(err), 0);
      chk("arst_pulse", 32'({step_valid, wrap_pulse}), 0);
      tick();
      reset = 1'b1;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/ripple_count_monitor.md
Name: ripple_count_monitor

Overview:
- Downstream consumer of the 3-bit asynchronous (ripple) down counter.
- Samples the counter's glitchy, asynchronous Q output into the system clock domain.
- Accepts a value only once it has been stable for STABLE_N samples.
- Validates each change as a legal single step, counts wrap-arounds into an extended count, and flags illegal jumps.

Parameters:
- CNT_W, 3: width of the sampled ripple count.
- EXT_W, 8: width of the wrap counter (upper part of full_count).
- STABLE_N, 2: consecutive equal synchronized samples required before a value is accepted. Legal range 2..15.
- DIR, 0: expected counting direction. 0 = down (legal step is −1 mod 2^CNT_W); 1 = up (+1 mod 2^CNT_W).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- q_in  input  CNT_W  raw ripple counter output; asynchronous to clk.
- clr  input  1  synchronous clear; returns the FSM to INIT and zeroes the counters.
- count_out  output  CNT_W  last accepted count value.
- full_count  output  EXT_W+CNT_W  {wrap_cnt, count_out}.
- step_valid  output  1  one-cycle pulse per accepted legal step.
- wrap_pulse  output  1  one-cycle pulse when an accepted step crosses the wrap boundary.
- err  output  1  sticky flag for an illegal jump.
- state  output  2  FSM state: 0 INIT, 1 TRACK, 2 ERR.

Behaviour:
- Reset (reset=0, asynchronous): takes effect immediately, with no clock edge needed.
  - s1, s2 and the history shift register clear to 0.
  - count_out=0, wrap_cnt=0, step_valid=0, wrap_pulse=0, err=0, state=INIT.
- Synchronizer: s1<=q_in, then s2<=s1. A history register holds the last STABLE_N values of s2.
- settled = the last STABLE_N s2 samples are all equal; the settled value is s2.
- Latency: a new q_in value is captured into s1 at edge E0. FSM outputs reflect it at edge E0+STABLE_N+1 (edge 3 with defaults).
- Pulses: step_valid and wrap_pulse are registered and high for exactly one cycle.
- INIT:
  - On settled: load count_out with s2, go to TRACK.
  - No step_valid or wrap_pulse is generated, and wrap_cnt is unchanged.
- TRACK:
  - Settled value == count_out: no action.
  - Settled value == count_out±1 mod 2^CNT_W, in the DIR direction: count_out<=value, step_valid=1.
    - Wrap case (DIR=0: 0→2^CNT_W−1; DIR=1: 2^CNT_W−1→0): additionally wrap_pulse=1 and wrap_cnt<=wrap_cnt+1 mod 2^EXT_W.
  - Any other settled value: err<=1, go to ERR; count_out is held and no step_valid is produced.
- ERR:
  - count_out and wrap_cnt are frozen and steps are ignored; err stays 1.
  - Exits only via clr or reset, except under the optional feature.
- clr=1 (any state): next edge sets state=INIT, count_out=0, wrap_cnt=0, err=0, pulses=0. The synchronizer is not cleared.
- clr coinciding with a settled step: clr wins and no pulse is produced.
- Source-rate requirement: the source must hold each value for at least STABLE_N+2 clk cycles. A double step inside one settle window is reported as an illegal jump.
- Glitch filtering: glitches shorter than STABLE_N cycles (ripple intermediates) never settle and are ignored.

Optional Feature:
- Macro: RCM_AUTORESYNC_EN
- Defined: ERR is not terminal. On the next settled value the FSM loads count_out with that value and returns to TRACK, with no step_valid or wrap_pulse. err remains sticky until clr or reset.
- Not defined: ERR is held until clr or reset.

Test Plan:
- Reset release with q_in=7 held (defaults): state=TRACK and count_out=7 by edge 3; full_count=0x007; step_valid never pulses.
- Down sequence 7,6,5,4,3,2,1,0,7, each held 10 cycles: 8 step_valid pulses, 1 wrap_pulse (on 0→7), final full_count={8'd1,3'd7}, err=0.
- From count_out=5, drive 2 and hold:
  - err=1, state=ERR, count_out stays 5, no step_valid; further legal steps are ignored.
  - clr for 1 cycle gives state=INIT, then a resync to q_in without a pulse.
  - With RCM_AUTORESYNC_EN: resync to 2 without clr, err=1.
- From count_out=5, drive q_in=4 for 1 cycle then back to 5 (glitch): no step_valid, no err, count_out=5.
- Mid-sequence, drive reset=0 between clock edges: all outputs 0 and state=INIT immediately, before the next edge.
- clr asserted on the same edge a legal step (5→4) would be accepted: state=INIT, count_out=0, wrap_cnt=0, no step_valid.
